// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bit-count constant for the I2C subordinate FSM
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    READ_DATA,
    ACK_DATA,
    WRITE_DATA,
    WAIT_ACK
  } state_e;
  localparam logic [8:0] LAST_BIT_COUNT = 9'd6;
endpackage

// File: rtl/i2c_state_machine.sv
// i2c_state_machine: SCL-clocked transaction phase tracker driving one-hot datapath strobes
module i2c_state_machine
  import i2c_pkg::*;
#(
  parameter logic [8:0] LAST_BIT = LAST_BIT_COUNT
) (
  input  logic       scl,
  input  logic       rst,
  input  logic       start_cond,
  input  logic       stop_cond,
  input  logic       address_match,
  input  logic       read_bit,
  input  logic       write_bit,
  input  logic [8:0] clock_count,
  output logic       read_address,
  output logic       write_ack,
  output logic       read_data,
  output logic       write_data
);
  state_e state_q, state_d;
  logic   last;
  assign last = clock_count == LAST_BIT;
  // state register; reset and bus events are folded into the next-state logic
  always_ff @(posedge scl) state_q <= state_d;
  // next state: rst, then START, then STOP, then per-phase progression
  always_comb begin
    state_d = state_q;
    case (state_q)
      ADDR:       state_d = last ? (address_match ? ACK_ADDR : IDLE) : ADDR;
      ACK_ADDR:   state_d = read_bit ? WRITE_DATA : write_bit ? READ_DATA : IDLE;
      READ_DATA:  state_d = last ? ACK_DATA : READ_DATA;
      ACK_DATA:   state_d = READ_DATA;
      WRITE_DATA: state_d = last ? WAIT_ACK : WRITE_DATA;
      WAIT_ACK:   state_d = WRITE_DATA;
      default:    state_d = IDLE;
    endcase
    state_d = rst ? IDLE : start_cond ? ADDR : stop_cond ? IDLE : state_d;
  end
  assign read_address = state_q == ADDR;
  assign write_ack    = state_q == ACK_ADDR || state_q == ACK_DATA;
  assign read_data    = state_q == READ_DATA;
  assign write_data   = state_q == WRITE_DATA;
endmodule

// File: tb/tb_i2c_state_machine.sv
// tb_i2c_state_machine: directed vectors checked against literals and a phase/direction model
module tb_i2c_state_machine;
  logic       scl = 0;
  logic       rst = 0, start_cond = 0, stop_cond = 0, address_match = 0;
  logic       read_bit = 0, write_bit = 0;
  logic [8:0] clock_count = 0;
  logic       read_address, write_ack, read_data, write_data;
  int total = 0, bad = 0;
  logic checks_on = 0;
  // model: busy flag, phase (0 address byte, 1 ack slot, 2 data byte), direction (0 unknown, 1 sub receives, 2 sub transmits)
  logic busy = 0;
  int   phase = 0, dir = 0;

  i2c_state_machine dut (
    .scl(scl), .rst(rst), .start_cond(start_cond), .stop_cond(stop_cond),
    .address_match(address_match), .read_bit(read_bit), .write_bit(write_bit),
    .clock_count(clock_count), .read_address(read_address), .write_ack(write_ack),
    .read_data(read_data), .write_data(write_data)
  );

  always #5 scl = ~scl;

  function automatic logic [3:0] model_out();
    if (!busy) return 4'b0000;
    return {phase == 0, phase == 1 && dir != 2, phase == 2 && dir == 1, phase == 2 && dir == 2};
  endfunction

  // model update from the bus rules on each scl rise
  always @(posedge scl) begin
    if (rst) busy = 0;
    else if (start_cond) begin busy = 1; phase = 0; dir = 0; end
    else if (stop_cond) busy = 0;
    else if (busy) begin
      if (phase == 0) begin
        if (clock_count == 9'd6) begin
          if (address_match) phase = 1; else busy = 0;
        end
      end else if (phase == 1) begin
        if (dir == 0) begin
          if (read_bit) begin dir = 2; phase = 2; end
          else if (write_bit) begin dir = 1; phase = 2; end
          else busy = 0;
        end else phase = 2;
      end else if (clock_count == 9'd6) phase = 1;
    end
    checks_on = 1;
  end

  // every-cycle comparison against the model, on the falling edge
  always @(negedge scl) if (checks_on) begin
    total++;
    if ({read_address, write_ack, read_data, write_data} !== model_out()) begin
      bad++;
      $display("FAIL model t=%0t got=%b want=%b", $time,
               {read_address, write_ack, read_data, write_data}, model_out());
    end
  end

  task automatic step(input logic r, s, p, m, rb, wb, input int cc, input logic [3:0] exp, input string nm);
    rst = r; start_cond = s; stop_cond = p; address_match = m;
    read_bit = rb; write_bit = wb; clock_count = 9'(cc);
    @(posedge scl); #1;
    total++;
    if ({read_address, write_ack, read_data, write_data} !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, {read_address, write_ack, read_data, write_data}, exp);
    end
  endtask

  initial begin
    step(1, 1, 0, 0, 0, 0, 0, 4'b0000, "reset1");
    step(1, 1, 0, 0, 0, 0, 0, 4'b0000, "reset2");
    step(0, 1, 0, 0, 0, 0, 0, 4'b1000, "rd_start");
    step(0, 0, 0, 1, 0, 0, 3, 4'b1000, "rd_addr_hold");
    step(0, 0, 0, 1, 0, 0, 6, 4'b0100, "rd_ack_addr");
    step(0, 0, 0, 0, 1, 0, 0, 4'b0001, "rd_write_data");
    step(0, 0, 0, 0, 0, 0, 2, 4'b0001, "rd_wd_hold");
    step(0, 0, 0, 0, 0, 0, 6, 4'b0000, "rd_wait_ack");
    step(0, 0, 0, 0, 0, 0, 0, 4'b0001, "rd_next_byte");
    step(0, 0, 0, 0, 0, 0, 7, 4'b0001, "rd_above_last");
    step(0, 0, 0, 0, 0, 0, 262, 4'b0001, "rd_full_width");
    step(0, 0, 0, 0, 0, 0, 6, 4'b0000, "rd_wait_ack2");
    step(0, 0, 0, 0, 0, 0, 0, 4'b0001, "rd_byte3");
    step(0, 0, 1, 0, 0, 0, 3, 4'b0000, "stop_in_wd");
    step(0, 0, 1, 0, 0, 0, 0, 4'b0000, "stop_held");
    step(0, 1, 1, 0, 0, 0, 0, 4'b1000, "start_beats_stop");
    step(0, 1, 0, 1, 0, 0, 6, 4'b1000, "start_held");
    step(0, 0, 0, 0, 0, 0, 6, 4'b0000, "addr_mismatch");
    step(0, 0, 0, 1, 1, 0, 6, 4'b0000, "idle_holds");
    step(0, 1, 0, 0, 0, 0, 0, 4'b1000, "wr_start");
    step(0, 0, 0, 1, 0, 0, 6, 4'b0100, "wr_ack_addr");
    step(0, 0, 0, 0, 0, 1, 0, 4'b0010, "wr_read_data");
    step(0, 0, 0, 0, 0, 0, 6, 4'b0100, "wr_ack_data");
    step(0, 0, 0, 0, 0, 0, 6, 4'b0010, "wr_next_byte");
    step(0, 0, 0, 0, 0, 0, 3, 4'b0010, "wr_hold");
    step(1, 0, 0, 0, 0, 0, 3, 4'b0000, "rst_mid_read");
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, "after_rst");
    step(0, 1, 0, 0, 0, 0, 0, 4'b1000, "both_start");
    step(0, 0, 0, 1, 0, 0, 6, 4'b0100, "both_ack");
    step(0, 0, 0, 0, 1, 1, 0, 4'b0001, "read_bit_wins");
    step(0, 1, 0, 0, 0, 0, 0, 4'b1000, "restart_from_wd");
    step(0, 0, 0, 1, 0, 0, 6, 4'b0100, "none_ack");
    step(0, 0, 0, 0, 0, 0, 0, 4'b0000, "no_rw_bit");
    step(0, 1, 0, 0, 0, 0, 0, 4'b1000, "w2_start");
    step(0, 0, 0, 1, 0, 0, 6, 4'b0100, "w2_ack");
    step(0, 0, 0, 0, 0, 1, 0, 4'b0010, "w2_rd");
    step(0, 1, 0, 0, 0, 0, 2, 4'b1000, "restart_from_rd");
    @(negedge scl);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_state_machine.md
# i2c_state_machine

Control FSM of the I2C subordinate interface. It tracks the current phase of an I2C transaction (address reception, acknowledge, data reception, data transmission) from bus-event inputs and an external bit counter. It drives one-hot phase strobes that enable the shift registers and the SDA driver. It is clocked by SCL and sits between the start/stop detector and bit counter upstream and the datapath downstream.

## Interface
- LAST_BIT, default 9'd6: value of `clock_count` that marks the final sampling edge of an 8-bit phase.
- scl  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start_cond  input  1  START or repeated-START detected, level, sampled on scl rise.
- stop_cond  input  1  STOP detected, level, sampled on scl rise.
- address_match  input  1  received 7-bit address equals own address; valid when `clock_count == LAST_BIT` in ADDR.
- read_bit  input  1  R/W bit = 1: controller reads, subordinate transmits.
- write_bit  input  1  R/W bit = 0: controller writes, subordinate receives.
- clock_count  input  9  bit counter within the current byte phase, from an external counter.
- read_address  output  1  high in ADDR; shift in address byte.
- write_ack  output  1  high in ACK_ADDR and ACK_DATA; subordinate drives SDA low.
- read_data  output  1  high in READ_DATA; shift in data byte.
- write_data  output  1  high in WRITE_DATA; shift out data byte.

## Operation
- States: IDLE, ADDR, ACK_ADDR, READ_DATA, ACK_DATA, WRITE_DATA, WAIT_ACK.
- Outputs are Moore-decoded from the state register. They are mutually exclusive. All are 0 in IDLE and in WAIT_ACK.
- Next-state priority on each scl rise:
  - rst: IDLE.
  - else start_cond: ADDR, from any state. This covers repeated START, and START wins over a simultaneous stop_cond.
  - else stop_cond: IDLE, from any state.
  - else the per-state rules below.
- IDLE: hold.
- ADDR:
  - `clock_count == LAST_BIT` and address_match: ACK_ADDR.
  - `clock_count == LAST_BIT` and no address_match: IDLE.
  - otherwise hold.
- ACK_ADDR: lasts exactly one cycle.
  - read_bit: WRITE_DATA.
  - else write_bit: READ_DATA.
  - else IDLE.
  - read_bit has priority if both are high.
- READ_DATA: `clock_count == LAST_BIT`: ACK_DATA; else hold.
- ACK_DATA: one cycle, then READ_DATA (next received byte).
- WRITE_DATA: `clock_count == LAST_BIT`: WAIT_ACK; else hold.
- WAIT_ACK: one cycle (controller ACK/NACK slot), then WRITE_DATA. A NACK ends the transfer through the STOP that follows.
- clock_count is compared by full 9-bit equality. Values above LAST_BIT are treated as "not last". The FSM never modifies or resets the counter.

## Timing
- Single clock domain (scl). No combinational path from any input to any output. Outputs change only after a scl rising edge.
- Reset value: state IDLE, all outputs 0, visible after the first scl rise with rst=1. rst asserted mid-transaction aborts on that edge.
- Latency:
  - start_cond high at edge N: read_address=1 after edge N.
  - Address match at edge M: write_ack=1 after M, for one cycle.
  - read_data or write_data follows at M+1.
- A held start_cond keeps the FSM in ADDR. A held stop_cond keeps it in IDLE.

## Structure
- Shared package `i2c_pkg`: state enum typedef (3-bit logic encoding) and `LAST_BIT_COUNT = 9'd6`, which is the default for LAST_BIT.
- No sub-module. Use one state register plus a combinational next-state and output decode in a single module.

## Test plan
- Reset: rst=1 for 2 edges, with start_cond=1 -> state IDLE, all outputs 0.
- Controller-read: start_cond pulse -> read_address=1; clock_count=6, address_match=1 -> write_ack=1 for one cycle; read_bit=1 -> write_data=1; clock_count=6 -> all outputs 0 for one cycle, then write_data=1.
- Controller-write: start -> ADDR; clock_count=6, match=1, then write_bit=1 -> read_data=1; clock_count=6 -> write_ack=1 one cycle, then read_data=1.
- Address mismatch: ADDR with clock_count=6, address_match=0 -> IDLE, all outputs 0.
- Stop then start: stop_cond=1 in WRITE_DATA -> IDLE; start_cond and stop_cond both 1 -> ADDR (read_address=1).
- Reset mid-READ_DATA: rst=1 at clock_count=3 -> IDLE on that edge, read_data=0.
